// File: rtl/lab_fsm_pkg.sv
// Shared constants and helpers for the lab FSM family of serial detectors.
package lab_fsm_pkg;

    localparam int DEF_N  = 4;
    localparam int DEF_CW = 8;
    localparam logic [DEF_N-1:0] DEF_RESET_PATTERN = 4'b1011;

    typedef enum logic {
        MODE_NON_OVERLAP = 1'b0,
        MODE_OVERLAP     = 1'b1
    } overlap_mode_e;

    // Bits needed to hold the values 0..max_val (at least one bit).
    function automatic int width_for(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) w++;
        return w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// CW-bit up counter with synchronous clear that sticks at its maximum value.
module sat_counter #(
    parameter int CW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [CW-1:0] o_count
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CW{1'b1}})) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/seq_detect_mealy.sv
// Mealy serial-pattern detector: runtime-loadable N-bit pattern, overlap and
// non-overlap modes, sample enable and a saturating match counter.
module seq_detect_mealy
    import lab_fsm_pkg::*;
#(
    parameter int            N             = DEF_N,
    parameter int            CW            = DEF_CW,
    parameter logic [N-1:0]  RESET_PATTERN = N'(DEF_RESET_PATTERN)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          x,
    input  logic          en,
    input  logic          load,
    input  logic [N-1:0]  pattern_in,
    input  logic          overlap,
    output logic          z,
    output logic          z_q,
    output logic [CW-1:0] match_count
);

    localparam int             FW        = width_for(N - 1);
    localparam logic [FW-1:0]  FILL_FULL = FW'(N - 1);

    logic [N-1:0]  r_pattern;
    logic [N-2:0]  r_hist;
    logic [FW-1:0] r_fill;
    logic          r_z_q;

    logic [N-1:0]  w_window;
    logic          w_accept;
    logic          w_full;
    logic          w_z;
    logic          w_restart;

    // Oldest history bit lands in the MSB, so the window lines up with the
    // pattern's first-received bit at N-1.
    assign w_window  = {r_hist, x};
    assign w_accept  = en & ~load;
    assign w_full    = (r_fill == FILL_FULL);
    assign w_z       = w_accept & w_full & (w_window == r_pattern);
    assign w_restart = w_z & (overlap_mode_e'(overlap) == MODE_NON_OVERLAP);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pattern <= RESET_PATTERN;
            r_hist    <= '0;
            r_fill    <= '0;
            r_z_q     <= 1'b0;
        end else begin
            r_z_q <= w_z;
            if (load) begin
                r_pattern <= pattern_in;
                r_hist    <= '0;
                r_fill    <= '0;
            end else if (en) begin
                if (w_restart) begin
                    r_hist <= '0;
                    r_fill <= '0;
                end else begin
                    r_hist <= w_window[N-2:0];
                    if (!w_full) r_fill <= r_fill + FW'(1);
                end
            end
        end
    end

    sat_counter #(.CW(CW)) u_count (
        .clock   (clock),
        .reset   (reset),
        .i_clr   (load),
        .i_inc   (w_z),
        .o_count (match_count)
    );

    assign z   = w_z;
    assign z_q = r_z_q;

endmodule

// File: tb/tb_seq_detect_mealy.sv
// Directed bench for seq_detect_mealy: a CW=8 instance and a CW=2 instance share stimulus.
module tb_seq_detect_mealy;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       x = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic       overlap = 1'b1;
    logic [3:0] pattern_in = 4'b0000;

    logic       z, z_q, z2, z_q2;
    logic [7:0] match_count;
    logic [1:0] mc2;

    int npass  = 0;
    int nfail  = 0;
    int ntotal = 0;

    always #5 clock = ~clock;

    seq_detect_mealy #(.N(4), .CW(8), .RESET_PATTERN(4'b1011)) dut (
        .clock(clock), .reset(reset), .x(x), .en(en), .load(load),
        .pattern_in(pattern_in), .overlap(overlap),
        .z(z), .z_q(z_q), .match_count(match_count)
    );

    seq_detect_mealy #(.N(4), .CW(2), .RESET_PATTERN(4'b1011)) dut2 (
        .clock(clock), .reset(reset), .x(x), .en(en), .load(load),
        .pattern_in(pattern_in), .overlap(overlap),
        .z(z2), .z_q(z_q2), .match_count(mc2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1: drive one cycle, check z mid-cycle, z_q after the edge.
    task automatic bitin(input logic xv, input logic ev, input logic ez, input string tag);
        x = xv; en = ev; load = 1'b0;
        @(negedge clock);
        chk({tag, ".z"}, 32'(z), 32'(ez));
        @(posedge clock); #1;
        chk({tag, ".zq"}, 32'(z_q), 32'(ez));
    endtask

    task automatic stream(input logic [15:0] bits, input int n, input logic [15:0] zexp,
                          input string tag);
        for (int i = n - 1; i >= 0; i--) bitin(bits[i], 1'b1, zexp[i], tag);
    endtask

    task automatic ldpat(input logic [3:0] p, input logic xv, input string tag);
        load = 1'b1; en = 1'b1; x = xv; pattern_in = p;
        @(negedge clock);
        chk({tag, ".z"}, 32'(z), 32'd0);
        @(posedge clock); #1;
        load = 1'b0; en = 1'b0;
        chk({tag, ".zq"}, 32'(z_q), 32'd0);
        chk({tag, ".cnt"}, 32'(match_count), 32'd0);
    endtask

    // Asserted at posedge+1 with en=1, x=1 so the detector would otherwise see data.
    task automatic do_reset(input string tag);
        reset = 1'b0; en = 1'b1; x = 1'b1;
        #1;
        chk({tag, ".cnt_async"}, 32'(match_count), 32'd0);
        @(negedge clock);
        chk({tag, ".z"}, 32'(z), 32'd0);
        chk({tag, ".zq"}, 32'(z_q), 32'd0);
        chk({tag, ".cnt2"}, 32'(mc2), 32'd0);
        @(posedge clock); #1;
        chk({tag, ".zq_edge"}, 32'(z_q), 32'd0);
        chk({tag, ".cnt"}, 32'(match_count), 32'd0);
        reset = 1'b1; en = 1'b0;
    endtask

    logic [12:0] sat_bits;
    logic [12:0] sat_z;
    logic [1:0]  sat_exp [4];
    int          k;

    initial begin
        #2;
        chk("rst.z", 32'(z), 32'd0);
        chk("rst.zq", 32'(z_q), 32'd0);
        chk("rst.cnt", 32'(match_count), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        // First match after power-up, then reset mid-stream.
        overlap = 1'b1;
        stream(16'b1011, 4, 16'b0001, "first");
        chk("first.cnt", 32'(match_count), 32'd1);
        bitin(1'b1, 1'b1, 1'b0, "partial");
        bitin(1'b0, 1'b1, 1'b0, "partial");
        do_reset("midrst");
        stream(16'b1011, 4, 16'b0001, "postrst");
        chk("postrst.cnt", 32'(match_count), 32'd1);

        // Overlapping detection.
        do_reset("rst_ovl");
        overlap = 1'b1;
        stream(16'b1011011, 7, 16'b0001001, "ovl");
        chk("ovl.cnt", 32'(match_count), 32'd2);

        // Non-overlapping detection.
        do_reset("rst_novl");
        overlap = 1'b0;
        stream(16'b1011011, 7, 16'b0001000, "novl");
        chk("novl.cnt", 32'(match_count), 32'd1);
        stream(16'b1011, 4, 16'b0001, "novl2");
        chk("novl2.cnt", 32'(match_count), 32'd2);

        // Enable gaps: held x=1 in the last gap would complete 1011 if en were ignored.
        do_reset("rst_gap");
        overlap = 1'b1;
        bitin(1'b1, 1'b1, 1'b0, "gap.b1");
        bitin(1'b1, 1'b0, 1'b0, "gap.g1");
        bitin(1'b0, 1'b1, 1'b0, "gap.b2");
        bitin(1'b1, 1'b0, 1'b0, "gap.g2");
        bitin(1'b1, 1'b0, 1'b0, "gap.g2");
        bitin(1'b1, 1'b1, 1'b0, "gap.b3");
        for (int i = 0; i < 3; i++) bitin(1'b1, 1'b0, 1'b0, "gap.g3");
        chk("gap.cnt0", 32'(match_count), 32'd0);
        bitin(1'b1, 1'b1, 1'b1, "gap.b4");
        chk("gap.cnt1", 32'(match_count), 32'd1);

        // Pattern load: window 101+x=1 equals the old pattern, so load must mask z.
        do_reset("rst_ld");
        overlap = 1'b1;
        stream(16'b1011, 4, 16'b0001, "preld");
        stream(16'b101, 3, 16'b000, "preld2");
        chk("preld.cnt", 32'(match_count), 32'd1);
        ldpat(4'b0110, 1'b1, "ld1");
        stream(16'b0110, 4, 16'b0001, "newpat");
        chk("newpat.cnt", 32'(match_count), 32'd1);
        // Load bit x=0 must be dropped, otherwise 0,1,1,0 would complete on the third bit.
        ldpat(4'b0110, 1'b0, "ld2");
        stream(16'b110, 3, 16'b000, "drop");
        chk("drop.cnt", 32'(match_count), 32'd0);

        // Saturation on the CW=2 instance.
        do_reset("rst_sat");
        overlap = 1'b1;
        sat_bits = 13'b1011011011011;
        sat_z    = 13'b0001001001001;
        sat_exp  = '{2'd1, 2'd2, 2'd3, 2'd3};
        k = 0;
        for (int i = 12; i >= 0; i--) begin
            bitin(sat_bits[i], 1'b1, sat_z[i], "sat");
            if (sat_z[i]) begin
                chk("sat.cnt2", 32'(mc2), 32'(sat_exp[k]));
                k++;
            end
        end
        chk("sat.cnt8", 32'(match_count), 32'd4);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
